// File: rtl/alarm_sound_ctrl.sv
// Alarm ringing controller: sequences the song player through RING/SNOOZE/IDLE with per-second timing.
// Latency: a pulse sampled on edge N is visible on playSound/snoozing after edge N (one cycle later).
// Backpressure: none; pulse inputs are consumed in the cycle they arrive, and ignored pulses are dropped.
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   alarm_enable        - level, alarm armed
//   alarm_trigger       - one-cycle pulse from timekeeping, alarm time matched
//   snooze, stop        - one-cycle debounced button pulses
//   playSound           - high while ringing, drives the song player
//   snoozing            - high while in snooze
//   snooze_count        - snoozes used in the current alarm event
//   missed              - sticky, a ring timed out without acknowledgement
module alarm_sound_ctrl #(
    parameter int TICKS_PER_SEC  = 100_000_000,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       alarm_enable,
    input  logic       alarm_trigger,
    input  logic       snooze,
    input  logic       stop,
    output logic       playSound,
    output logic       snoozing,
    output logic [1:0] snooze_count,
    output logic       missed
);

    // Prescaler width; a one-cycle second still needs a 1-bit counter.
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [TW-1:0] TICK_MAX        = TW'(TICKS_PER_SEC - 1);
    localparam logic [15:0]   RING_LAST_SEC   = 16'(RING_SECONDS - 1);
    localparam logic [15:0]   SNOOZE_LAST_SEC = 16'(SNOOZE_SECONDS - 1);
    localparam logic [1:0]    SNOOZE_LIMIT    = 2'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic [15:0]     sec_cnt;
    logic            sec_tick;
    logic            ring_done;
    logic            snooze_done;
    logic            snooze_ok;
    logic [1:0]      snooze_count_nxt;
    logic            missed_nxt;

    assign sec_tick = (tick_cnt == TICK_MAX);

    // A duration ends on the tick that would bring sec_cnt up to the limit,
    // so the state lasts exactly SECONDS*TICKS_PER_SEC cycles from entry.
    assign ring_done   = sec_tick && (sec_cnt == RING_LAST_SEC);
    assign snooze_done = sec_tick && (sec_cnt == SNOOZE_LAST_SEC);
    assign snooze_ok   = (snooze_count < SNOOZE_LIMIT);

    // Next-state and bookkeeping.
    always_comb begin
        state_nxt        = state;
        snooze_count_nxt = snooze_count;
        missed_nxt       = missed;

        unique case (state)
            IDLE: begin
                if (alarm_trigger && alarm_enable) begin
                    state_nxt        = RING;
                    snooze_count_nxt = 2'd0;
                    missed_nxt       = 1'b0;
                end
            end

            RING: begin
                if (!alarm_enable) begin
                    state_nxt = IDLE;
                end else if (stop) begin
                    // stop beats both snooze and a same-cycle timeout
                    state_nxt = IDLE;
                end else if (snooze && snooze_ok) begin
                    state_nxt        = SNOOZE;
                    snooze_count_nxt = snooze_count + 2'd1;
                end else if (ring_done) begin
                    // A snooze at the limit falls through here, so it neither
                    // restarts the timer nor masks the timeout.
                    state_nxt  = IDLE;
                    missed_nxt = 1'b1;
                end
            end

            SNOOZE: begin
                if (!alarm_enable || stop) begin
                    state_nxt = IDLE;
                end else if (snooze_done) begin
                    state_nxt = RING;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, bookkeeping registers and timers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            snooze_count <= 2'd0;
            missed       <= 1'b0;
            tick_cnt     <= '0;
            sec_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            snooze_count <= snooze_count_nxt;
            missed       <= missed_nxt;

            // Timers restart on every transition so each new state starts
            // with a full period; they are parked while idle.
            if ((state_nxt != state) || (state == IDLE)) begin
                tick_cnt <= '0;
                sec_cnt  <= '0;
            end else if (sec_tick) begin
                tick_cnt <= '0;
                sec_cnt  <= sec_cnt + 16'd1;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    // Outputs are straight decodes of the state flops, so they are glitch-free
    // and playSound drops for a whole snooze between rings, restarting the tune.
    assign playSound = (state == RING);
    assign snoozing  = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_sound_ctrl.sv
// Testbench for alarm_sound_ctrl: directed scenarios plus random pulses against a cycle-count reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: none.
module tb_alarm_sound_ctrl;

    localparam int TPS     = 10;
    localparam int RING_S  = 3;
    localparam int SNZ_S   = 2;
    localparam int MAX_S   = 2;
    localparam int RING_CY = RING_S * TPS;
    localparam int SNZ_CY  = SNZ_S * TPS;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       alarm_enable = 1'b0;
    logic       alarm_trigger = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       playSound;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic       missed;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 ringing, 2 snoozing; m_cyc = cycles spent in the mode so far.
    int m_mode = 0;
    int m_cyc  = 0;
    int m_cnt  = 0;
    int m_miss = 0;

    int ps_run = 0;

    alarm_sound_ctrl #(
        .TICKS_PER_SEC (TPS),
        .RING_SECONDS  (RING_S),
        .SNOOZE_SECONDS(SNZ_S),
        .MAX_SNOOZES   (MAX_S)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alarm_enable (alarm_enable),
        .alarm_trigger(alarm_trigger),
        .snooze       (snooze),
        .stop         (stop),
        .playSound    (playSound),
        .snoozing     (snoozing),
        .snooze_count (snooze_count),
        .missed       (missed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Apply the spec rules for one clock edge given the inputs present at that edge.
    task automatic model_edge(input bit rst, input bit en, input bit trg, input bit snz, input bit stp);
        int nxt;
        if (rst) begin
            m_mode = 0; m_cyc = 0; m_cnt = 0; m_miss = 0;
            return;
        end
        nxt = m_mode;
        case (m_mode)
            0: if (trg && en) begin nxt = 1; m_cnt = 0; m_miss = 0; end
            1: begin
                if (!en || stp)                 nxt = 0;
                else if (snz && m_cnt < MAX_S) begin nxt = 2; m_cnt++; end
                else if (m_cyc + 1 == RING_CY) begin nxt = 0; m_miss = 1; end
            end
            default: begin
                if (!en || stp)                nxt = 0;
                else if (m_cyc + 1 == SNZ_CY)  nxt = 1;
            end
        endcase
        if (nxt != m_mode) m_cyc = 0;
        else               m_cyc++;
        m_mode = nxt;
    endtask

    // One clock cycle: drive, let the edge happen, update model, compare.
    task automatic cyc(input bit en, input bit trg, input bit snz, input bit stp, input bit rst);
        alarm_enable  = en;
        alarm_trigger = trg;
        snooze        = snz;
        stop          = stp;
        reset         = rst;
        @(posedge clock);
        model_edge(rst, en, trg, snz, stp);
        #1;
        chk("playSound",    int'(playSound),    (m_mode == 1) ? 1 : 0);
        chk("snoozing",     int'(snoozing),     (m_mode == 2) ? 1 : 0);
        chk("snooze_count", int'(snooze_count), m_cnt);
        chk("missed",       int'(missed),       m_miss);
        if (playSound) ps_run++;
        @(negedge clock);
    endtask

    task automatic idle_n(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(en, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clock);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);

        // Plain ring that times out: exactly RING_CY cycles of playSound.
        idle_n(4, 1);
        ps_run = 0;
        cyc(1, 1, 0, 0, 0);
        idle_n(RING_CY + 5, 1);
        chk("ring_len", ps_run, RING_CY);
        chk("missed_after_timeout", int'(missed), 1);

        // Snooze after 10 cycles, then a fresh ring; a new trigger clears missed.
        cyc(1, 1, 0, 0, 0);
        chk("missed_cleared", int'(missed), 0);
        idle_n(9, 1);
        cyc(1, 0, 1, 0, 0);
        chk("snooze_taken", int'(snooze_count), 1);
        ps_run = 0;
        idle_n(SNZ_CY - 1, 1);
        chk("no_ring_during_snooze", ps_run, 0);
        idle_n(RING_CY + 3, 1);
        chk("fresh_ring_len", ps_run, RING_CY);

        // Three snoozes in successive rings: third one ignored, then timeout.
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle_n(4, 1);
            cyc(1, 0, 1, 0, 0);
            if (k < 2) idle_n(SNZ_CY, 1);
        end
        chk("snooze_limit", int'(snooze_count), MAX_S);
        chk("still_ringing", int'(playSound), 1);
        idle_n(RING_CY, 1);
        chk("limit_timeout_missed", int'(missed), 1);

        // stop + snooze together in RING: stop wins.
        cyc(1, 1, 0, 0, 0);
        idle_n(3, 1);
        cyc(1, 0, 1, 1, 0);
        chk("stop_wins_count", int'(snooze_count), 0);
        idle_n(3, 1);

        // Disable mid-snooze, trigger while disabled, then re-enabled trigger.
        cyc(1, 1, 0, 0, 0);
        idle_n(2, 1);
        cyc(1, 0, 1, 0, 0);
        idle_n(5, 1);
        cyc(0, 0, 0, 0, 0);
        chk("disable_to_idle", int'(snoozing), 0);
        idle_n(3, 0);
        cyc(0, 1, 0, 0, 0);
        chk("disabled_trigger", int'(playSound), 0);
        cyc(1, 1, 0, 0, 0);
        chk("reenable_count", int'(snooze_count), 0);

        // Reset mid-ring, then a duplicate trigger that must not restart the timer.
        idle_n(5, 1);
        cyc(1, 0, 0, 0, 1);
        chk("reset_mid_ring", int'(playSound), 0);
        ps_run = 0;
        cyc(1, 1, 0, 0, 0);
        idle_n(10, 1);
        cyc(1, 1, 0, 0, 0);
        idle_n(RING_CY, 1);
        chk("dup_trigger_len", ps_run, RING_CY);

        // Random pulses, with occasional enable changes and resets.
        for (int i = 0; i < 4000; i++) begin
            bit en_r;
            en_r = ($urandom_range(0, 99) < 3) ? ~alarm_enable : alarm_enable;
            cyc(en_r,
                $urandom_range(0, 14) == 0,
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 599) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
